usb_ep_buf_rd_stream: RTL and testbench
=======================================

Name: usb_ep_buf_rd_stream

Overview:
Reader front-end for an endpoint packet buffer. It accepts a start byte address and a length, then issues byte reads on the buffer's registered read port. The data comes back one cycle after each read enable. The block presents it to the USB TX packet engine as a valid/ready byte stream with last-byte marking and a completion pulse. A 2-entry internal skid FIFO absorbs the read latency so the block sustains 1 byte/cycle under arbitrary backpressure.

Parameters:
AWIDTH, 11, buffer byte-address width; addresses wrap modulo 2^AWIDTH
LWIDTH, 11, transfer length width; legal lengths are 0 to 2^LWIDTH-1 bytes

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous, active-low reset
cmd_addr  in  AWIDTH  start byte address, sampled on command handshake
cmd_len  in  LWIDTH  payload byte count, sampled on command handshake
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
abort  in  1  cancel active transfer
buf_rd_addr_0  out  AWIDTH  buffer read address
buf_rd_en_0  out  1  buffer read enable; data returns next cycle
buf_rd_data_1  in  8  buffer read data, valid the cycle after buf_rd_en_0
out_data  out  8  stream byte
out_last  out  1  marks final byte of stream
out_valid  out  1  stream byte valid
out_ready  in  1  consumer accepts byte
done  out  1  one-cycle completion pulse
busy  out  1  high when not IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, cmd_ready=1, busy=0, buf_rd_en_0=0, buf_rd_addr_0=0, out_valid=0, out_data=0, out_last=0, done=0. The FIFO is empty and all counters are 0.
- States:
  - IDLE: command handshake (cmd_valid & cmd_ready) latches addr/len and goes to RUN. If len=0 it goes to FIN instead.
  - RUN: issue reads and stream bytes. Goes to FIN on the handshake of the byte carrying out_last.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Fetch rule: assert buf_rd_en_0 only when remaining-to-fetch > 0 and (FIFO occupancy + in-flight read − pop this cycle) < 2.
  - The address post-increments by 1 per issued read, wrapping modulo 2^AWIDTH.
  - The FIFO never overflows; the block never issues more than 2 reads ahead of the consumer.
- Capture: buf_rd_data_1 is pushed into the FIFO the cycle after each buf_rd_en_0.
- Output registers:
  - out_data/out_valid/out_last come from the FIFO head.
  - They hold stable while out_valid & !out_ready.
  - out_valid never drops without a handshake, except on abort.
- Latency with out_ready held high:
  - First buf_rd_en_0 is in the cycle after command acceptance.
  - First out_valid is the cycle after that.
  - Then 1 byte/cycle with no bubbles.
- out_last: high with the last payload byte (feature off).
- done: asserted the cycle after the last handshake. cmd_ready returns high the cycle after done.
- len=0 (feature off): no bytes and no reads; done pulses in the cycle after acceptance.
- cmd_valid while busy: ignored, no state change.
- abort:
  - In RUN: next cycle the state is IDLE, the FIFO is flushed, out_valid=0, and any in-flight read result is discarded. No done pulse.
  - A same-cycle output handshake counts as transferred by the consumer.
  - In IDLE or FIN: abort has no effect, and done still pulses.
- Reset mid-transfer: immediate return to reset values.

Optional Feature:
Macro: USB_EP_BUF_RD_CRC_EN
- Defined:
  - A CRC16 engine (poly 0x8005, init 0xFFFF, LSB-first, result inverted) updates on every payload byte handshake.
  - After the last payload byte the block emits 2 extra bytes: CRC[7:0], then CRC[15:8].
  - out_last is on the second CRC byte only.
  - len=0 emits exactly 0x00, 0x00.
  - The CRC resets on command acceptance and on abort.
- Undefined: no CRC logic; the stream is the payload only.

Test Plan:
1. Buffer[0x010..0x013]=11 22 33 44; cmd addr=0x010 len=4; out_ready=1 → buf_rd_en_0 in 4 consecutive cycles starting the cycle after accept. Output is 11,22,33,44 on consecutive cycles, out_last with 44, done the next cycle, then cmd_ready=1.
2. Same command, out_ready toggling 1,0,0,1,0,1… → identical byte sequence with no drops or duplicates. out_data is stable while stalled and never more than 2 reads are outstanding.
3. addr=0x7FE len=4 (AWIDTH=11) → read addresses 0x7FE, 0x7FF, 0x000, 0x001 in order.
4. len=0 → no buf_rd_en_0 and no out_valid, done 1 cycle after accept. With USB_EP_BUF_RD_CRC_EN: output 0x00, then 0x00 with out_last.
5. len=8, abort after 2 handshakes → out_valid=0 and busy=0 the next cycle, no done. A following command addr=0x020 len=3 streams correct data from a clean state.
6. With USB_EP_BUF_RD_CRC_EN, random payloads of 1–64 bytes → CRC bytes match the software model. CRC16 over payload+CRC bytes gives the residue 0x800D (non-inverted register).

Source files
------------

// File: rtl/usb_ep_buf_rd_stream.sv
// Endpoint buffer reader: issues byte reads and streams the data out with valid/ready, last and done.
// Optional USB_EP_BUF_RD_CRC_EN appends the inverted CRC16 (LSB-first, poly 0x8005) as two trailing bytes.
module usb_ep_buf_rd_stream #(
   parameter int unsigned AWIDTH = 11,
   parameter int unsigned LWIDTH = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [LWIDTH-1:0] cmd_len,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              abort,
   output logic [AWIDTH-1:0] buf_rd_addr_0,
   output logic              buf_rd_en_0,
   input  logic [7:0]        buf_rd_data_1,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

   state_t            state_q;
   logic [AWIDTH-1:0] addr_q;
   logic [LWIDTH-1:0] fetch_rem_q;
   logic [LWIDTH-1:0] out_rem_q;
   logic              infl_q;
   logic [7:0]        fifo_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        cnt_q;

   logic              run;
   logic              fifo_ne;
   logic              pay_valid;
   logic              pay_pop;
   logic              fifo_pop;
   logic              push;
   logic [7:0]        pay_data;
   logic [1:0]        occ;

`ifdef USB_EP_BUF_RD_CRC_EN
   logic [15:0]       crc_q;
   logic              crc_sel_q;

   function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int unsigned i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction
`endif

   // The head is the FIFO when it holds data, else the read result landing this cycle (bypass).
   always_comb begin
      run       = (state_q == S_RUN);
      fifo_ne   = (cnt_q != 2'd0);
      pay_valid = run && (fifo_ne || infl_q);
      pay_data  = fifo_ne ? fifo_q[rd_ptr_q] : (infl_q ? buf_rd_data_1 : 8'h00);
      out_valid = pay_valid;
      out_data  = pay_data;
      out_last  = pay_valid && (out_rem_q == LWIDTH'(1));
`ifdef USB_EP_BUF_RD_CRC_EN
      out_last  = 1'b0;
      if (run && (out_rem_q == '0)) begin
         out_valid = 1'b1;
         out_data  = crc_sel_q ? ~crc_q[15:8] : ~crc_q[7:0];
         out_last  = crc_sel_q;
      end
`endif
      pay_pop       = pay_valid && out_ready;
      fifo_pop      = pay_pop && fifo_ne;
      push          = infl_q && !(pay_pop && !fifo_ne);
      occ           = cnt_q + {1'b0, infl_q} - {1'b0, pay_pop};
      buf_rd_en_0   = run && !abort && (fetch_rem_q != '0) && (occ < 2'd2);
      buf_rd_addr_0 = addr_q;
      cmd_ready     = (state_q == S_IDLE);
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         fetch_rem_q <= '0;
         out_rem_q   <= '0;
         infl_q      <= 1'b0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= '0;
`ifdef USB_EP_BUF_RD_CRC_EN
         crc_q       <= 16'hFFFF;
         crc_sel_q   <= 1'b0;
`endif
      end else begin
         infl_q <= buf_rd_en_0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  addr_q      <= cmd_addr;
                  fetch_rem_q <= cmd_len;
                  out_rem_q   <= cmd_len;
`ifdef USB_EP_BUF_RD_CRC_EN
                  crc_q       <= 16'hFFFF;
                  crc_sel_q   <= 1'b0;
                  state_q     <= S_RUN;
`else
                  state_q     <= (cmd_len == '0) ? S_FIN : S_RUN;
`endif
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_q  <= S_IDLE;
                  cnt_q    <= '0;
                  wr_ptr_q <= 1'b0;
                  rd_ptr_q <= 1'b0;
`ifdef USB_EP_BUF_RD_CRC_EN
                  crc_q    <= 16'hFFFF;
                  crc_sel_q <= 1'b0;
`endif
               end else begin
                  if (buf_rd_en_0) begin
                     addr_q      <= addr_q + AWIDTH'(1);
                     fetch_rem_q <= fetch_rem_q - LWIDTH'(1);
                  end
                  if (push) begin
                     fifo_q[wr_ptr_q] <= buf_rd_data_1;
                     wr_ptr_q         <= !wr_ptr_q;
                  end
                  if (fifo_pop) rd_ptr_q <= !rd_ptr_q;
                  cnt_q <= cnt_q + {1'b0, push} - {1'b0, fifo_pop};
                  if (pay_pop) out_rem_q <= out_rem_q - LWIDTH'(1);
`ifdef USB_EP_BUF_RD_CRC_EN
                  if (pay_pop) crc_q <= crc16_upd(crc_q, pay_data);
                  if (out_valid && out_ready && !pay_valid) crc_sel_q <= 1'b1;
`endif
                  if (out_valid && out_ready && out_last) state_q <= S_FIN;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               cnt_q    <= '0;
               wr_ptr_q <= 1'b0;
               rd_ptr_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_ep_buf_rd_stream.sv
// Directed bench for usb_ep_buf_rd_stream: cycle timing, backpressure, address wrap, len=0 and abort.
module tb_usb_ep_buf_rd_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] cmd_addr;
   logic [10:0] cmd_len;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        abort;
   logic [10:0] buf_rd_addr_0;
   logic        buf_rd_en_0;
   logic [7:0]  buf_rd_data_1;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        done;
   logic        busy;

   usb_ep_buf_rd_stream #(.AWIDTH(11), .LWIDTH(11)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .abort(abort),
      .buf_rd_addr_0(buf_rd_addr_0), .buf_rd_en_0(buf_rd_en_0), .buf_rd_data_1(buf_rd_data_1),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Buffer model with a registered read port
   logic [7:0] mem [2048];
   always @(posedge clk) if (buf_rd_en_0) buf_rd_data_1 <= mem[buf_rd_addr_0];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [10:0] rd_addr[$];
   int          rd_cyc[$];
   logic [7:0]  hs_data[$];
   logic        hs_last[$];
   int          hs_cyc[$];
   int          acc_cyc, done_cyc, n_done, max_ahead, n_unstable;
   logic        rdy_at_done;
   logic        stalled_prev;
   logic [7:0]  prev_data;
   logic        prev_last;

   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (buf_rd_en_0) begin rd_addr.push_back(buf_rd_addr_0); rd_cyc.push_back(cyc); end
         if (out_valid && out_ready) begin
            hs_data.push_back(out_data); hs_last.push_back(out_last); hs_cyc.push_back(cyc);
         end
         if (done) begin n_done++; done_cyc = cyc; rdy_at_done = cmd_ready; end
         if (int'(rd_addr.size()) - int'(hs_data.size()) > max_ahead)
            max_ahead = int'(rd_addr.size()) - int'(hs_data.size());
         if (stalled_prev && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            n_unstable++;
         stalled_prev = out_valid && !out_ready;
         prev_data    = out_data;
         prev_last    = out_last;
      end
   end

   task automatic clear_log();
      rd_addr.delete(); rd_cyc.delete(); hs_data.delete(); hs_last.delete(); hs_cyc.delete();
      acc_cyc = -100; done_cyc = -100; n_done = 0; max_ahead = 0; n_unstable = 0;
      rdy_at_done = 1'bx; stalled_prev = 1'b0;
   endtask

   function automatic logic [63:0] pack_data();
      logic [63:0] w = '0;
      foreach (hs_data[i]) w = {w[55:0], hs_data[i]};
      return w;
   endfunction

   function automatic logic [63:0] pack_last();
      logic [63:0] m = '0;
      foreach (hs_last[i]) m[i] = hs_last[i];
      return m;
   endfunction

   task automatic run_cmd(input logic [10:0] a, input logic [10:0] l, input bit tog, input int abort_after);
      logic [5:0] pat;
      int         tp;
      bit         fin;
      pat = 6'b101001;   // bit0 first: 1,0,0,1,0,1
      tp  = 0;
      fin = 1'b0;
      clear_log();
      @(posedge clk); #1;
      cmd_addr = a; cmd_len = l; cmd_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 300 && !fin; i++) begin
         if (n_done > 0) begin
            fin = 1'b1;
         end else if (abort_after > 0 && int'(hs_data.size()) >= abort_after) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("abort_out_valid", {63'd0, out_valid}, 64'd0);
            check("abort_busy", {63'd0, busy}, 64'd0);
            repeat (4) @(posedge clk);
            #1;
            fin = 1'b1;
         end else begin
            if (tog) begin out_ready = pat[tp]; tp = (tp + 1) % 6; end
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      check("terminated", {63'd0, fin}, 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[11'h010] = 8'h11; mem[11'h011] = 8'h22; mem[11'h012] = 8'h33; mem[11'h013] = 8'h44;
      mem[11'h7FE] = 8'hA1; mem[11'h7FF] = 8'hB2; mem[11'h000] = 8'hC3; mem[11'h001] = 8'hD4;
      mem[11'h020] = 8'hE0; mem[11'h021] = 8'hE1; mem[11'h022] = 8'hE2;
      rst_n = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
      clear_log();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_rd_en", {63'd0, buf_rd_en_0}, 64'd0);
      check("rst_rd_addr", {53'd0, buf_rd_addr_0}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", {56'd0, out_data}, 64'd0);
      check("rst_out_last", {63'd0, out_last}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);

      // Full-rate transfer, cycle-exact
      run_cmd(11'h010, 11'd4, 1'b0, 0);
      check("t1_reads", rd_addr.size(), 4);
      check("t1_first_rd_lat", 64'(rd_cyc[0] - acc_cyc), 64'd1);
      check("t1_last_rd_lat", 64'(rd_cyc[3] - acc_cyc), 64'd4);
      check("t1_data", pack_data(), 64'h11223344);
      check("t1_first_out_lat", 64'(hs_cyc[0] - acc_cyc), 64'd2);
      check("t1_last_out_lat", 64'(hs_cyc[3] - acc_cyc), 64'd5);
      check("t1_last_mask", pack_last(), 64'b1000);
      check("t1_done_lat", 64'(done_cyc - acc_cyc), 64'd6);
      check("t1_done_count", 64'(n_done), 64'd1);
      check("t1_ready_at_done", {63'd0, rdy_at_done}, 64'd0);
      check("t1_ready_after", {63'd0, cmd_ready}, 64'd1);

      // Backpressure
      run_cmd(11'h010, 11'd4, 1'b1, 0);
      check("t2_count", hs_data.size(), 4);
      check("t2_data", pack_data(), 64'h11223344);
      check("t2_last_mask", pack_last(), 64'b1000);
      check("t2_ahead_le2", {63'd0, max_ahead <= 2}, 64'd1);
      check("t2_stable", 64'(n_unstable), 64'd0);
      check("t2_done_count", 64'(n_done), 64'd1);

      // Address wrap
      run_cmd(11'h7FE, 11'd4, 1'b0, 0);
      check("t3_addr0", {53'd0, rd_addr[0]}, 64'h7FE);
      check("t3_addr1", {53'd0, rd_addr[1]}, 64'h7FF);
      check("t3_addr2", {53'd0, rd_addr[2]}, 64'h000);
      check("t3_addr3", {53'd0, rd_addr[3]}, 64'h001);
      check("t3_data", pack_data(), 64'hA1B2C3D4);

      // Zero length
      run_cmd(11'h010, 11'd0, 1'b0, 0);
      check("t4_reads", rd_addr.size(), 0);
`ifdef USB_EP_BUF_RD_CRC_EN
      check("t4_count", hs_data.size(), 2);
      check("t4_data", pack_data(), 64'h0000);
      check("t4_last_mask", pack_last(), 64'b10);
`else
      check("t4_count", hs_data.size(), 0);
      check("t4_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
`endif
      check("t4_done_count", 64'(n_done), 64'd1);

      // Abort after two handshakes, then a clean follow-up command
      run_cmd(11'h030, 11'd8, 1'b0, 2);
      check("t5_no_done", 64'(n_done), 64'd0);
      check("t5_idle", {63'd0, cmd_ready}, 64'd1);
      run_cmd(11'h020, 11'd3, 1'b0, 0);
`ifndef USB_EP_BUF_RD_CRC_EN
      check("t5b_data", pack_data(), 64'hE0E1E2);
      check("t5b_last_mask", pack_last(), 64'b100);
`endif
      check("t5b_done_count", 64'(n_done), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
